// File: rtl/cfh_sched.sv
// Two-stage, 8-word butterfly scheduler around a shared 2-cycle-latency 4-input butterfly.
// Loads a frame, issues four butterfly groups, writes results back in place, then streams the frame out.
module cfh_sched (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] bf_i0,
  output logic [11:0] bf_i1,
  output logic [11:0] bf_i2,
  output logic [11:0] bf_i3,
  input  logic [11:0] bf_o0,
  input  logic [11:0] bf_o1,
  input  logic [11:0] bf_o2,
  input  logic [11:0] bf_o3,
  output logic [11:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_S0   = 3'd1,
    ST_W0   = 3'd2,
    ST_S1   = 3'd3,
    ST_W1   = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  state_t      state_q;
  logic        phase_q;
  logic [2:0]  idx_q;
  logic [11:0] x_q [0:7];
  logic [2:0]  tag0_q;
  logic [2:0]  tag1_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [11:0] out_data_q;

  logic        issue_vld_d;
  logic [1:0]  issue_slot_d;

  // Buffer index of operand/destination k for issue slot 0..3 (stage-0 pair, then stage-1 pair).
  function automatic logic [2:0] slot_idx(input logic [1:0] slot, input logic [1:0] k);
    logic [11:0] map;
    logic [2:0]  res;
    case (slot)
      2'd0:    map = {3'd5, 3'd4, 3'd1, 3'd0};
      2'd1:    map = {3'd7, 3'd6, 3'd3, 3'd2};
      2'd2:    map = {3'd6, 3'd2, 3'd4, 3'd0};
      2'd3:    map = {3'd7, 3'd3, 3'd5, 3'd1};
      default: map = 12'd0;
    endcase
    case (k)
      2'd0:    res = map[2:0];
      2'd1:    res = map[5:3];
      2'd2:    res = map[8:6];
      2'd3:    res = map[11:9];
      default: res = 3'd0;
    endcase
    return res;
  endfunction

  // Operands are read straight from the buffer in the issue cycle so stage-1 sees settled stage-0 results.
  always_comb begin
    issue_vld_d  = (state_q == ST_S0) || (state_q == ST_S1);
    issue_slot_d = {(state_q == ST_S1), phase_q};
    if (issue_vld_d) begin
      bf_i0 = x_q[slot_idx(issue_slot_d, 2'd0)];
      bf_i1 = x_q[slot_idx(issue_slot_d, 2'd1)];
      bf_i2 = x_q[slot_idx(issue_slot_d, 2'd2)];
      bf_i3 = x_q[slot_idx(issue_slot_d, 2'd3)];
    end else begin
      bf_i0 = 12'd0;
      bf_i1 = 12'd0;
      bf_i2 = 12'd0;
      bf_i3 = 12'd0;
    end
  end

  // Control FSM, buffer, issue-tag pipe and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_LOAD;
      phase_q     <= 1'b0;
      idx_q       <= 3'd0;
      tag0_q      <= 3'd0;
      tag1_q      <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 12'd0;
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= 12'd0;
      end
    end else begin
      tag0_q <= {issue_vld_d, issue_slot_d};
      tag1_q <= tag0_q;
      // Tag bit 2 marks a live issue two cycles ago; results land in o0..o3 destination order.
      if (tag1_q[2]) begin
        x_q[slot_idx(tag1_q[1:0], 2'd0)] <= bf_o0;
        x_q[slot_idx(tag1_q[1:0], 2'd1)] <= bf_o1;
        x_q[slot_idx(tag1_q[1:0], 2'd2)] <= bf_o2;
        x_q[slot_idx(tag1_q[1:0], 2'd3)] <= bf_o3;
      end else begin
        tag1_q <= tag0_q;
      end
      case (state_q)
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            x_q[idx_q] <= in_data;
            idx_q      <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q    <= ST_S0;
              phase_q    <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_S0, ST_W0, ST_S1: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            state_q <= state_t'(state_q + 3'd1);
          end else begin
            state_q <= state_q;
          end
        end
        ST_W1: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= x_q[0];
          end else begin
            state_q <= ST_W1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (idx_q == 3'd7) begin
              state_q     <= ST_LOAD;
              idx_q       <= 3'd0;
              out_valid_q <= 1'b0;
              out_data_q  <= 12'd0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              idx_q      <= idx_q + 3'd1;
              out_data_q <= x_q[idx_q + 3'd1];
            end
          end else begin
            state_q <= ST_OUT;
          end
        end
        default: begin
          state_q     <= ST_LOAD;
          phase_q     <= 1'b0;
          idx_q       <= 3'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          out_data_q  <= 12'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cfh_sched.sv
// Bench for cfh_sched: behavioural 2-cycle butterfly, frame table, and an output scoreboard queue.
module tb_cfh_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bf_i0, bf_i1, bf_i2, bf_i3;
  logic [11:0] bf_o0, bf_o1, bf_o2, bf_o3;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  typedef struct packed {
    logic [7:0][11:0] din;
    logic [7:0][11:0] exp;
    logic [3:0]       gaps;
    logic [3:0]       stall_at;
    logic             hold_valid;
  } vec_t;

  vec_t        tbl [5];
  logic [11:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [47:0] p1, p2;

  cfh_sched dut (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bf_i0(bf_i0), .bf_i1(bf_i1), .bf_i2(bf_i2), .bf_i3(bf_i3),
    .bf_o0(bf_o0), .bf_o1(bf_o1), .bf_o2(bf_o2), .bf_o3(bf_o3),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Butterfly with two register stages: operands of cycle k are results in cycle k+2.
  always @(posedge CLK) begin
    p1 <= {bf_i3, bf_i2, bf_i1, bf_i0};
    p2 <= {12'(p1[23:12] - p1[47:36]), 12'(p1[11:0] - p1[35:24]),
           12'(p1[23:12] + p1[47:36]), 12'(p1[11:0] + p1[35:24])};
  end
  assign {bf_o3, bf_o2, bf_o1, bf_o0} = p2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted output beat is compared against the oldest expected word.
  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {20'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("out_data", {20'd0, out_data}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference transform: stage 0 pairs (a, a+4), stage 1 pairs (a, a+2) within each half.
  function automatic logic [7:0][11:0] ref_xform(input logic [7:0][11:0] d);
    logic [7:0][11:0] y;
    logic [11:0]      t;
    y = d;
    for (int a = 0; a < 4; a++) begin
      t = y[a];
      y[a]     = t + y[a + 4];
      y[a + 4] = t - y[a + 4];
    end
    for (int a = 0; a < 8; a++) begin
      if ((a % 4) < 2) begin
        t = y[a];
        y[a]     = t + y[a + 2];
        y[a + 2] = t - y[a + 2];
      end
    end
    return y;
  endfunction

  task automatic load(input logic [7:0][11:0] d, input int gaps);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, gaps)) begin
        in_valid = 1'b0;
        chk("in_ready_gap", {31'd0, in_ready}, 32'd1);
        chk("busy_load", {31'd0, busy}, 32'd0);
        step();
      end
      in_valid = 1'b1;
      in_data  = d[i];
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_first(input logic [7:0][11:0] d, input logic hold);
    int n;
    n = 1;
    while (out_valid !== 1'b1 && n < 30) begin
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("busy", {31'd0, busy}, 32'd1);
      if (n == 1) begin
        chk("issue0_i0", {20'd0, bf_i0}, {20'd0, d[0]});
        chk("issue0_i3", {20'd0, bf_i3}, {20'd0, d[5]});
      end
      if (n == 2) chk("issue1_i1", {20'd0, bf_i1}, {20'd0, d[3]});
      if (n == 5) begin
        chk("issue2_i0", {20'd0, bf_i0}, {20'd0, 12'(d[0] + d[4])});
        chk("issue2_i2", {20'd0, bf_i2}, {20'd0, 12'(d[2] + d[6])});
      end
      if (n == 6) chk("issue3_i1", {20'd0, bf_i1}, {20'd0, 12'(d[1] - d[5])});
      if (n == 3 || n == 4 || n == 7 || n == 8)
        chk("bf_idle_zero", {20'd0, bf_i0 | bf_i1 | bf_i2 | bf_i3}, 32'd0);
      in_valid = hold;
      in_data  = 12'($urandom);
      step();
      n++;
    end
    chk("latency", n, 32'd9);
  endtask

  task automatic drain(input int stall_at);
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          if (exp_q.size() > 0) chk("stall_hold", {20'd0, out_data}, {20'd0, exp_q[0]});
          step();
        end
      end
      out_ready = 1'b1;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_out", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b0;
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v.exp[i]);
    load(v.din, int'(v.gaps));
    wait_first(v.din, v.hold_valid);
    drain(int'(v.stall_at));
  endtask

  initial begin
    vec_t zv;
    RESET = 1'b1; in_data = 12'd0; in_valid = 1'b0; out_ready = 1'b0;

    // Element [7] is written first in each packed literal below.
    for (int i = 0; i < 8; i++) tbl[0].din[i] = 12'(i + 1);
    tbl[0].exp = {12'h000, 12'h000, 12'hFF8, 12'hFF8, 12'hFFC, 12'hFFC, 12'h014, 12'h010};
    tbl[0].gaps = 4'd0; tbl[0].stall_at = 4'd8; tbl[0].hold_valid = 1'b0;
    for (int i = 0; i < 8; i++) tbl[1].din[i] = 12'h7FF;
    tbl[1].exp = {12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFC, 12'hFFC};
    tbl[1].gaps = 4'd2; tbl[1].stall_at = 4'd2; tbl[1].hold_valid = 1'b0;
    tbl[2].din = {12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h800};
    tbl[2].exp = {12'h000, 12'h800, 12'h000, 12'h800, 12'h000, 12'h800, 12'h000, 12'h800};
    tbl[2].gaps = 4'd1; tbl[2].stall_at = 4'd8; tbl[2].hold_valid = 1'b1;
    for (int e = 3; e < 5; e++) begin
      for (int i = 0; i < 8; i++) tbl[e].din[i] = 12'($urandom);
      tbl[e].exp = ref_xform(tbl[e].din);
    end
    tbl[3].gaps = 4'd3; tbl[3].stall_at = 4'd7; tbl[3].hold_valid = 1'b1;
    tbl[4].gaps = 4'd0; tbl[4].stall_at = 4'd8; tbl[4].hold_valid = 1'b0;

    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {20'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bf", {20'd0, bf_i0 | bf_i1 | bf_i2 | bf_i3}, 32'd0);
    RESET = 1'b0;

    for (int e = 0; e < 5; e++) run_frame(tbl[e]);

    // Abort a frame during stage-1 issue (cycle L+6), with a competing input beat under reset.
    load(tbl[0].din, 0);
    repeat (5) step();
    RESET = 1'b1; in_valid = 1'b1; in_data = 12'hABC;
    exp_q.delete();
    step();
    RESET = 1'b0; in_valid = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_data", {20'd0, out_data}, 32'd0);
    chk("abort_bf", {20'd0, bf_i0 | bf_i1 | bf_i2 | bf_i3}, 32'd0);
    zv.din = '0; zv.exp = '0; zv.gaps = 4'd1; zv.stall_at = 4'd8; zv.hold_valid = 1'b0;
    run_frame(zv);
    run_frame(tbl[0]);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfh_sched.md
CFH_SCHED -- requirements
Module: cfh_sched

Interface
REQ-001 Parameters: none; frame size fixed at 8 words, data width fixed at 12 bits.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  reset; reset RESET, synchronous, active-high; clock CLK.
REQ-004 in_data  input  12  sample word of the incoming frame.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data; a beat transfers when in_valid and in_ready are both high.
REQ-007 bf_i0..bf_i3  output  12 each  operands to the shared 4-input butterfly unit.
REQ-008 bf_o0..bf_o3  input  12 each  butterfly results.
REQ-009 out_data  output  12  transformed frame word.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts; a beat transfers when out_valid and out_ready are both high.
REQ-012 busy  output  1  high in every state except LOAD.

Function
REQ-013 Butterfly contract: operands driven during cycle k appear on bf_o0..3 during cycle k+2; bf_o0=i0+i2, bf_o1=i1+i3, bf_o2=i0-i2, bf_o3=i1-i3, all mod 2^12.
REQ-014 Buffer: 8 x 12-bit registers x[0..7]; all arithmetic wraps mod 2^12 with no saturation or overflow flag.
REQ-015 States: LOAD, S0 (2 cycles), W0 (2 cycles), S1 (2 cycles), W1 (2 cycles), OUT; transitions occur only in the listed order, then OUT returns to LOAD.
REQ-016 LOAD: in_ready=1; accepted beats write x[0], x[1], ... x[7] in order; after the 8th accepted beat (cycle L), the next state is S0.
REQ-017 Stage-0 issue: cycle L+1 drives (x0,x1,x4,x5), and its results write back to x0,x1,x4,x5; cycle L+2 drives (x2,x3,x6,x7), and its results write back to x2,x3,x6,x7.
REQ-018 Stage-1 issue: cycle L+5 drives (x0,x4,x2,x6), and its results write back to x0,x4,x2,x6; cycle L+6 drives (x1,x5,x3,x7), and its results write back to x1,x5,x3,x7.
REQ-019 Writeback: bf_o0..3 are captured at the end of the cycle 2 after the issue cycle, into the four destinations in order o0..o3; a 2-deep issue-tag shift register selects the destination.
REQ-020 Stage-1 operands are read no earlier than the cycle after the last stage-0 writeback; no bypass paths exist.
REQ-021 bf_i0..3 shall be 0 in every cycle with no issue.
REQ-022 OUT: out_valid=1 from cycle L+9; out_data=x[idx] with idx starting at 0; idx advances only on an accepted beat.
REQ-023 Under out_ready=0 backpressure, out_valid and out_data hold unchanged.
REQ-024 After x[7] is accepted, the state is LOAD on the next cycle with out_valid=0 and in_ready=1.
REQ-025 Input end-to-end latency: 9 cycles from the last accepted input beat to the first out_valid, with no stalls.
REQ-026 in_ready=0 in every state except LOAD; in_valid is ignored outside LOAD, and no buffer write occurs.
REQ-027 A partial frame held in LOAD waits indefinitely; bubbles in in_valid are allowed.
REQ-028 out_ready is ignored outside OUT.

Reset
REQ-029 When RESET is high at a clock edge, the next state is LOAD with in_ready=1, out_valid=0, out_data=0, busy=0, bf_i0..3=0, x[0..7]=0, load/output index=0, and the tag pipe is cleared.
REQ-030 RESET asserted mid-frame (any state) discards the frame; results still in flight in the butterfly are not written back after reset.
REQ-031 RESET has priority over all handshakes in the same cycle.

Verification
REQ-032 Frame 1,2,3,4,5,6,7,8 with out_ready=1 -> output sequence 0x010,0x014,0xFFC,0xFFC,0xFF8,0xFF8,0x000,0x000; first out_valid exactly 9 cycles after the 8th input beat.
REQ-033 All inputs 0x7FF (wrap check) -> output sequence 0xFFC,0xFFC,0x000,0x000,0x000,0x000,0x000,0x000.
REQ-034 In OUT, hold out_ready=0 for 5 cycles after word 2 -> word 2 is held stable, no words are lost or duplicated, and the output order is unchanged.
REQ-035 RESET asserted at cycle L+6 (during stage-1 issue), then a new frame of all zeros -> all-zero output, with no residue from the aborted frame; in_ready=1 the cycle after reset.
REQ-036 Random in_valid gaps and in_valid held high during busy -> only 8 beats are accepted per frame, and in_ready=0 throughout busy.
REQ-037 Two back-to-back frames -> in_ready rises the cycle after the 8th output beat, and the second frame's result is independent of the first.
